gray_pixel_streamer: RTL and testbench

Upstream input stage of the edge detector. It accepts an Avalon-ST RGB pixel stream and converts each pixel to 8-bit grayscale in a 2-stage pipeline. It checks frame framing (sop/eop) against IMG_X_SIZE*IMG_Y_SIZE and presents grayscale pixels with valid/ready handshake. The edge detector controller consumes the output and pulses grayReady_i for each pixel it writes to image memory.

---
 rtl/gray_pixel_streamer.sv | 133 +++++++++++++
 tb/tb_gray_pixel_streamer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_pixel_streamer.sv
// RGB Avalon-ST to 8-bit grayscale converter with a 2-stage pipeline and a
// sop/eop framing check against a frame of IMG_X_SIZE*IMG_Y_SIZE pixels.
module gray_pixel_streamer #(
    parameter int IMG_X_SIZE = 100,
    parameter int IMG_Y_SIZE = 100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] RgbData_i,
    input  logic        rgbValid_i,
    output logic        rgbReady_o,
    input  logic        sop_i,
    input  logic        eop_i,
    output logic [7:0]  GrayImg_o,
    output logic        grayValid_o,
    input  logic        grayReady_i,
    output logic        grayLast_o,
    output logic        frameDone_o,
    output logic        frameError_o,
    input  logic        errClear_i
);
    // state    | meaning
    // WAIT_SOP | idle between frames, beats without sop are dropped
    // IN_FRAME | r_cnt pixels of the current frame already forwarded
    localparam int N  = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);

    typedef enum logic {WAIT_SOP = 1'b0, IN_FRAME = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_beat_num;
    logic          w_accept, w_adv1, w_adv2;
    logic          w_fwd, w_last, w_err_set;
    logic          r_s1_valid, r_s1_last;
    logic [15:0]   r_s1_pr, r_s1_pg, r_s1_pb;
    logic          r_s2_valid, r_s2_last;
    logic [7:0]    r_s2_gray, w_gray;
    logic          r_done, r_err;

    assign w_adv2     = ~r_s2_valid | grayReady_i;
    assign w_adv1     = ~r_s1_valid | w_adv2;
    assign w_accept   = rgbValid_i & w_adv1;
    assign rgbReady_o = w_adv1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= WAIT_SOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A sop always restarts numbering, so sop+eop on one beat is a 1-pixel frame.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_num  = (sop_i || r_state == WAIT_SOP) ? CW'(1) : r_cnt + CW'(1);
        if (w_accept && (sop_i || r_state == IN_FRAME)) begin
            if (eop_i || w_beat_num == N_C) begin
                w_state_nxt = WAIT_SOP;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = IN_FRAME;
                w_cnt_nxt   = w_beat_num;
            end
        end
    end

    always_comb begin
        w_fwd     = w_accept && (sop_i || r_state == IN_FRAME);
        w_last    = w_fwd && (eop_i || w_beat_num == N_C);
        w_err_set = 1'b0;
        if (w_accept) begin
            w_err_set = (r_state == WAIT_SOP) ? ~sop_i : sop_i;
            if (w_last && (w_beat_num != N_C || !eop_i))
                w_err_set = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= w_fwd;
            r_s1_last  <= w_last;
            r_s1_pr    <= 16'(RgbData_i[23:16]) * 16'd77;
            r_s1_pg    <= 16'(RgbData_i[15:8])  * 16'd150;
            r_s1_pb    <= 16'(RgbData_i[7:0])   * 16'd29;
        end
    end

    // Worst-case sum is 65408, so 16 bits never overflow.
    assign w_gray = 8'((r_s1_pr + r_s1_pg + r_s1_pb + 16'd128) >> 8);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_gray  <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid & r_s1_last;
            if (r_s1_valid)
                r_s2_gray <= w_gray;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= r_s2_valid & grayReady_i & r_s2_last;
            if (w_err_set)
                r_err <= 1'b1;
            else if (errClear_i)
                r_err <= 1'b0;
        end
    end

    assign GrayImg_o    = r_s2_gray;
    assign grayValid_o  = r_s2_valid;
    assign grayLast_o   = r_s2_last;
    assign frameDone_o  = r_done;
    assign frameError_o = r_err;
endmodule

// File: tb/tb_gray_pixel_streamer.sv
// Bench for gray_pixel_streamer (4x4 frames): random pixel streams compared
// against a queue-based reference model of the grayscale and framing rules.
module tb_gray_pixel_streamer;
    localparam int NPIX = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] RgbData_i = '0;
    logic        rgbValid_i = 1'b0;
    logic        rgbReady_o;
    logic        sop_i = 1'b0;
    logic        eop_i = 1'b0;
    logic [7:0]  GrayImg_o;
    logic        grayValid_o;
    logic        grayReady_i = 1'b1;
    logic        grayLast_o;
    logic        frameDone_o;
    logic        frameError_o;
    logic        errClear_i = 1'b0;

    gray_pixel_streamer #(.IMG_X_SIZE(4), .IMG_Y_SIZE(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .RgbData_i(RgbData_i),
        .rgbValid_i(rgbValid_i), .rgbReady_o(rgbReady_o),
        .sop_i(sop_i), .eop_i(eop_i), .GrayImg_o(GrayImg_o),
        .grayValid_o(grayValid_o), .grayReady_i(grayReady_i),
        .grayLast_o(grayLast_o), .frameDone_o(frameDone_o),
        .frameError_o(frameError_o), .errClear_i(errClear_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [23:0] rgb; logic sop; logic eop; } beat_t;
    typedef struct { logic [7:0] g; logic l; } out_t;

    beat_t stim[$];
    out_t  expq[$];
    int    m_pos = 0;
    logic  exp_err = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    pat[4] = '{1, 0, 0, 1};

    int         n_out, last_idx, done_cnt, first_acc, first_val;
    logic [7:0] out_data[64];

    function automatic void add_beat(logic [23:0] rgb, logic s, logic e);
        beat_t b;
        b.rgb = rgb; b.sop = s; b.eop = e;
        stim.push_back(b);
    endfunction

    // Reference: pixel position within the frame, 0 when no frame is open.
    function automatic void model_accept(beat_t b);
        int r, g, bl;
        out_t o;
        if (m_pos == 0 && !b.sop) begin
            exp_err = 1'b1;
            return;
        end
        if (b.sop) begin
            if (m_pos != 0) exp_err = 1'b1;
            m_pos = 1;
        end else begin
            m_pos++;
        end
        r  = int'(b.rgb[23:16]);
        g  = int'(b.rgb[15:8]);
        bl = int'(b.rgb[7:0]);
        o.g = 8'((77 * r + 150 * g + 29 * bl + 128) / 256);
        o.l = b.eop || (m_pos == NPIX);
        if (o.l) begin
            if (!b.eop || m_pos != NPIX) exp_err = 1'b1;
            m_pos = 0;
        end
        expq.push_back(o);
    endfunction

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random; vmode: 0 valid held, 1 random gaps
    task automatic run_stream(input int rmode, input int vmode);
        int         cyc;
        bit         hold, pend_done, hs, exp_rdy;
        logic [7:0] hg;
        logic       hl;
        out_t       o;
        cyc = 0; hold = 0; pend_done = 0; hg = '0; hl = 1'b0;
        n_out = 0; last_idx = -1; done_cnt = 0; first_acc = -1; first_val = -1;
        while ((stim.size() > 0 || expq.size() > 0) && cyc < 2000) begin
            @(posedge clk_i); #1;
            rgbValid_i = (stim.size() > 0) && (vmode == 0 || $urandom_range(3) != 0);
            if (stim.size() > 0) begin
                RgbData_i = stim[0].rgb; sop_i = stim[0].sop; eop_i = stim[0].eop;
            end else begin
                RgbData_i = '0; sop_i = 1'b0; eop_i = 1'b0;
            end
            grayReady_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 4] != 0 : $urandom_range(1) != 0;
            @(negedge clk_i);
            vectors += 3;
            if (frameError_o !== exp_err) begin
                miscompares++;
                $display("FAIL frameError cyc=%0d got=%b exp=%b", cyc, frameError_o, exp_err);
            end
            if (frameDone_o !== pend_done) begin
                miscompares++;
                $display("FAIL frameDone cyc=%0d got=%b exp=%b", cyc, frameDone_o, pend_done);
            end
            if (frameDone_o === 1'b1) done_cnt++;
            exp_rdy = !(expq.size() == 2 && !grayReady_i);
            if (rgbReady_o !== exp_rdy) begin
                miscompares++;
                $display("FAIL rgbReady cyc=%0d got=%b exp=%b", cyc, rgbReady_o, exp_rdy);
            end
            if (hold) begin
                vectors++;
                if (grayValid_o !== 1'b1 || GrayImg_o !== hg || grayLast_o !== hl) begin
                    miscompares++;
                    $display("FAIL stall_stable cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             cyc, grayValid_o, GrayImg_o, grayLast_o, hg, hl);
                end
            end
            if (grayValid_o === 1'b1 && first_val < 0) first_val = cyc;
            hs = (grayValid_o === 1'b1) && grayReady_i;
            if (grayValid_o === 1'b1 && expq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL stale_output cyc=%0d got valid=1 data=%h exp valid=0", cyc, GrayImg_o);
            end else if (hs) begin
                o = expq.pop_front();
                vectors++;
                if (GrayImg_o !== o.g || grayLast_o !== o.l) begin
                    miscompares++;
                    $display("FAIL out[%0d] got d=%h l=%b exp d=%h l=%b", n_out, GrayImg_o, grayLast_o, o.g, o.l);
                end
                if (n_out < 64) out_data[n_out] = GrayImg_o;
                if (grayLast_o === 1'b1 && last_idx < 0) last_idx = n_out;
                n_out++;
            end
            if (rgbValid_i && rgbReady_o === 1'b1) begin
                if (first_acc < 0) first_acc = cyc;
                model_accept(stim.pop_front());
            end
            hold = (grayValid_o === 1'b1) && !grayReady_i;
            hg = GrayImg_o; hl = grayLast_o;
            pend_done = hs && (grayLast_o === 1'b1);
            cyc++;
        end
        vectors++;
        if (cyc >= 2000) begin
            miscompares++;
            $display("FAIL stream_timeout got pending_in=%0d pending_out=%0d exp 0/0", stim.size(), expq.size());
            stim.delete(); expq.delete();
        end
        @(posedge clk_i); #1;
        rgbValid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; grayReady_i = 1'b1;
        @(negedge clk_i);
        vectors += 2;
        if (frameDone_o !== pend_done) begin
            miscompares++;
            $display("FAIL frameDone_tail got=%b exp=%b", frameDone_o, pend_done);
        end
        if (frameDone_o === 1'b1) done_cnt++;
        if (frameError_o !== exp_err) begin
            miscompares++;
            $display("FAIL frameError_tail got=%b exp=%b", frameError_o, exp_err);
        end
    endtask

    task automatic pulse_err_clear();
        @(posedge clk_i); #1;
        errClear_i = 1'b1;
        @(posedge clk_i); #1;
        errClear_i = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (GrayImg_o !== 8'h00 || grayValid_o !== 1'b0 || grayLast_o !== 1'b0 ||
            frameDone_o !== 1'b0 || frameError_o !== 1'b0 || rgbReady_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got d=%h v=%b l=%b dn=%b er=%b rdy=%b exp 00 0 0 0 0 1",
                     GrayImg_o, grayValid_o, grayLast_o, frameDone_o, frameError_o, rgbReady_o);
        end
    endtask

    task automatic test_white_frame();
        for (int i = 0; i < NPIX; i++) add_beat(24'hFFFFFF, i == 0, i == NPIX - 1);
        run_stream(0, 0);
        vectors += 4;
        if (first_val - first_acc !== 2) begin
            miscompares++;
            $display("FAIL white_latency got=%0d exp=2", first_val - first_acc);
        end
        if (n_out !== 16 || last_idx !== 15) begin
            miscompares++;
            $display("FAIL white_count got n=%0d last=%0d exp n=16 last=15", n_out, last_idx);
        end
        if (out_data[0] !== 8'hFF || out_data[15] !== 8'hFF) begin
            miscompares++;
            $display("FAIL white_data got %h/%h exp ff/ff", out_data[0], out_data[15]);
        end
        if (done_cnt !== 1 || frameError_o !== 1'b0) begin
            miscompares++;
            $display("FAIL white_done got done=%0d err=%b exp done=1 err=0", done_cnt, frameError_o);
        end
    endtask

    task automatic test_arith();
        logic [23:0] cols[5];
        logic [7:0]  want[5];
        cols = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000, 24'h646464};
        want = '{8'd77, 8'd149, 8'd29, 8'd0, 8'd100};
        for (int i = 0; i < NPIX; i++)
            add_beat(i < 5 ? cols[i] : 24'($urandom), i == 0, i == NPIX - 1);
        run_stream(0, 0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_data[i] !== want[i]) begin
                miscompares++;
                $display("FAIL arith[%0d] rgb=%h got=%0d exp=%0d", i, cols[i], out_data[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NPIX; i++) add_beat(24'($urandom), i == 0, i == NPIX - 1);
        run_stream(1, 0);
        vectors++;
        if (n_out !== 16 || last_idx !== 15 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL backpressure got n=%0d last=%0d done=%0d exp 16/15/1", n_out, last_idx, done_cnt);
        end
    endtask

    task automatic test_framing_errors();
        for (int i = 0; i < 3; i++) add_beat(24'($urandom), 1'b0, 1'b0);
        run_stream(0, 0);
        vectors++;
        if (n_out !== 0 || frameError_o !== 1'b1) begin
            miscompares++;
            $display("FAIL no_sop_drop got n=%0d err=%b exp n=0 err=1", n_out, frameError_o);
        end
        for (int i = 0; i < 10; i++) add_beat(24'($urandom), i == 0, i == 9);
        run_stream(0, 0);
        vectors++;
        if (n_out !== 10 || last_idx !== 9 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL early_eop got n=%0d last=%0d done=%0d exp 10/9/1", n_out, last_idx, done_cnt);
        end
        pulse_err_clear();
        @(negedge clk_i);
        vectors++;
        if (frameError_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got=%b exp=0", frameError_o);
        end
        for (int i = 0; i < NPIX; i++) add_beat(24'($urandom), i == 0, 1'b0);
        run_stream(2, 0);
        vectors++;
        if (n_out !== 16 || last_idx !== 15 || frameError_o !== 1'b1) begin
            miscompares++;
            $display("FAIL missing_eop got n=%0d last=%0d err=%b exp 16/15/1", n_out, last_idx, frameError_o);
        end
    endtask

    task automatic test_reset_midframe();
        int acc, guard;
        acc = 0; guard = 0;
        for (int i = 0; i < NPIX; i++) add_beat(24'($urandom), i == 0, i == NPIX - 1);
        grayReady_i = 1'b1;
        while (acc < 7 && guard < 100) begin
            @(posedge clk_i); #1;
            rgbValid_i = 1'b1;
            RgbData_i = stim[acc].rgb; sop_i = stim[acc].sop; eop_i = stim[acc].eop;
            @(negedge clk_i);
            if (rgbReady_o === 1'b1) acc++;
            guard++;
        end
        @(posedge clk_i); #1;
        rgbValid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; grayReady_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (grayValid_o !== 1'b1 || rgbReady_o !== 1'b0 || acc !== 7) begin
            miscompares++;
            $display("FAIL pre_reset_full got v=%b rdy=%b acc=%0d exp 1/0/7", grayValid_o, rgbReady_o, acc);
        end
        #2 rst_i = 1'b1;
        #1;
        vectors++;
        if (grayValid_o !== 1'b0 || GrayImg_o !== 8'h00 || grayLast_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b d=%h l=%b exp 0/00/0", grayValid_o, GrayImg_o, grayLast_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; grayReady_i = 1'b1;
        stim.delete(); expq.delete(); m_pos = 0; exp_err = 1'b0;
        for (int i = 0; i < NPIX; i++) add_beat(24'($urandom), i == 0, i == NPIX - 1);
        run_stream(0, 0);
        vectors++;
        if (n_out !== 16 || last_idx !== 15 || first_val - first_acc !== 2) begin
            miscompares++;
            $display("FAIL after_reset got n=%0d last=%0d lat=%0d exp 16/15/2", n_out, last_idx, first_val - first_acc);
        end
    endtask

    task automatic test_sop_restart();
        pulse_err_clear();
        for (int i = 0; i < 21; i++) add_beat(24'($urandom), i == 0 || i == 5, i == 20);
        run_stream(0, 1);
        vectors++;
        if (n_out !== 21 || last_idx !== 20 || frameError_o !== 1'b1) begin
            miscompares++;
            $display("FAIL sop_restart got n=%0d last=%0d err=%b exp 21/20/1", n_out, last_idx, frameError_o);
        end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(18, 1);
            for (int i = 0; i < len; i++)
                add_beat(24'($urandom),
                         (i == 0) ? ($urandom_range(7) != 0) : ($urandom_range(15) == 0),
                         (i == len - 1) ? ($urandom_range(4) != 0) : 1'b0);
            run_stream(2, 1);
        end
    endtask

    initial begin
        test_reset();
        test_white_frame();
        test_arith();
        test_backpressure();
        test_framing_errors();
        test_reset_midframe();
        test_sop_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
